dac_stream_sched: RTL and testbench
===================================

// Module: dac_stream_sched
// PURPOSE
//  Sequences the DAC output path: selects one of two sample sources (stream / test tone),
//  paces samples at a programmable rate and drives data plus an active-high enable into the
//  DDR DAC output interface. Handles power-up settling, orderly stop and underflow accounting.
//  Sits between the sample generators and the DAC pad interface, in the same clk domain.
// PARAMETERS
//  WIDTH       14   DAC sample width, offset-binary
//  WARMUP_CYC  16   cycles of mid-scale output with enable high before samples flow (>=1)
//  DRAIN_CYC   8    cycles of mid-scale output after stop before enable drops (>=1)
// PORTS
//  clk            in   1      system/DAC clock
//  resetn         in   1      asynchronous reset, active low
//  start          in   1      pulse: begin output (honoured only in IDLE)
//  stop           in   1      pulse: end output (honoured in WARMUP and RUN)
//  src_sel        in   1      0 = source 0 (stream), 1 = source 1 (test tone); latched at start
//  rate_div       in   8      sample period = rate_div+1 clocks; latched at start
//  s0_data        in   WIDTH  source 0 sample
//  s0_valid       in   1      source 0 sample available
//  s0_ready       out  1      source 0 sample consumed this cycle
//  s1_data        in   WIDTH  source 1 sample
//  s1_valid       in   1      source 1 sample available
//  s1_ready       out  1      source 1 sample consumed this cycle
//  underflow_clr  in   1      synchronous clear of underflow_cnt
//  dac_data       out  WIDTH  sample to DAC interface (registered)
//  dac_en         out  1      DAC enable, active high (registered)
//  busy           out  1      high in any state other than IDLE
//  underflow_cnt  out  16     saturating count of missed sample ticks
// BEHAVIOUR
//  Reset (resetn low, async): state IDLE, dac_data = MID = 1<<(WIDTH-1), dac_en = 0, busy = 0,
//   s0_ready = s1_ready = 0, underflow_cnt = 0, tick counter = 0. Reset mid-run aborts at once.
//  States: IDLE -> WARMUP -> RUN -> DRAIN -> IDLE.
//  IDLE: dac_en 0, dac_data MID. start & !stop -> WARMUP, latch src_sel, rate_div; start & stop -> stay IDLE.
//  WARMUP: dac_en 1, dac_data MID, counts WARMUP_CYC cycles then -> RUN; stop -> DRAIN immediately.
//  RUN: tick counter runs 0..rate_div_l, tick when counter == rate_div_l (first tick
//   rate_div_l+1 cycles after RUN entry; rate_div 0 = tick every cycle).
//   On tick, selected source valid: its ready = 1 for that cycle (combinational from state,
//   tick, valid); dac_data <= its data, visible next cycle (latency 1). Unselected ready always 0.
//   On tick, selected source not valid: dac_data holds last value; underflow_cnt +1, saturates at 0xFFFF.
//   ready is never asserted outside a tick; only one sample consumed per tick.
//  stop in RUN -> DRAIN on next cycle; a tick coinciding with stop is still consumed.
//  DRAIN: dac_en 1, dac_data MID, DRAIN_CYC cycles then -> IDLE (dac_en 0 on IDLE entry).
//  start outside IDLE and stop in IDLE/DRAIN are ignored.
//  underflow_clr has priority over a same-cycle increment (count becomes 0).
//  busy = (state != IDLE), registered with state.
// TESTING
//  1 reset: resetn low mid-RUN -> dac_en 0, dac_data 0x2000, underflow_cnt 0 asynchronously.
//  2 start, src_sel=0, rate_div=3, s0_valid=1 data ramp 1,2,3.. -> dac_en 1 after start, 16 cycles
//    of 0x2000, then s0_ready every 4th cycle, dac_data 1,2,3 one cycle after each ready.
//  3 same as 2 with s0_valid dropped for 2 ticks -> dac_data holds, underflow_cnt = 2, s0_ready low.
//  4 src_sel=1, rate_div=0 -> s1_ready every cycle in RUN, s0_ready never; toggling src_sel
//    during RUN has no effect.
//  5 stop in RUN -> 8 cycles dac_data 0x2000 with dac_en 1, then dac_en 0, busy 0; stop in WARMUP
//    -> DRAIN directly; start+stop same cycle in IDLE -> stays IDLE.
//  6 force 65536 underflows -> underflow_cnt stays 0xFFFF; underflow_clr with a same-cycle miss -> 0.

Source files
------------

// File: rtl/dac_stream_sched.sv
// DAC output sequencer: source select, programmable sample pacing, warm-up/drain at mid-scale,
// and saturating underflow accounting. Handshake: a source sample moves when its valid and
// ready are both high in the same cycle; ready is only ever raised on a RUN tick.
module dac_stream_sched #(
  parameter int WIDTH      = 14,
  parameter int WARMUP_CYC = 16,
  parameter int DRAIN_CYC  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             src_sel,
  input  logic [7:0]       rate_div,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic             underflow_clr,
  output logic [WIDTH-1:0] dac_data,
  output logic             dac_en,
  output logic             busy,
  output logic [15:0]      underflow_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int PH_MAX = (WARMUP_CYC > DRAIN_CYC) ? WARMUP_CYC : DRAIN_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] WARM_LAST  = PH_W'(WARMUP_CYC - 1);
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [PH_W-1:0]  ph_cnt;
  logic [7:0]       tick_cnt;
  logic [7:0]       rate_l;
  logic             src_l;
  logic             tick;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             take;
  logic             miss;

  assign state_dbg = state;
  assign tick      = (state == S_RUN) && (tick_cnt == rate_l);
  assign sel_valid = src_l ? s1_valid : s0_valid;
  assign sel_data  = src_l ? s1_data : s0_data;
  assign take      = tick && sel_valid;
  assign miss      = tick && !sel_valid;
  assign s0_ready  = take && !src_l;
  assign s1_ready  = take && src_l;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start && !stop) state_next = S_WARMUP;
      S_WARMUP: begin
        if (stop)                        state_next = S_DRAIN;
        else if (ph_cnt == WARM_LAST)    state_next = S_RUN;
      end
      S_RUN:    if (stop) state_next = S_DRAIN;
      S_DRAIN:  if (ph_cnt == DRAIN_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      ph_cnt        <= '0;
      tick_cnt      <= '0;
      rate_l        <= '0;
      src_l         <= 1'b0;
      dac_data      <= MID;
      dac_en        <= 1'b0;
      busy          <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != S_IDLE);
      dac_en <= (state_next != S_IDLE);

      if (state == S_IDLE && start && !stop) begin
        src_l  <= src_sel;
        rate_l <= rate_div;
      end

      // One counter times both the warm-up and the drain phases.
      if (state_next != state)
        ph_cnt <= '0;
      else if (state == S_WARMUP || state == S_DRAIN)
        ph_cnt <= ph_cnt + PH_W'(1);

      if (state == S_RUN && state_next == S_RUN && !tick)
        tick_cnt <= tick_cnt + 8'd1;
      else
        tick_cnt <= '0;

      // A sample taken on the stop cycle is consumed but never shown: drain outputs mid-scale.
      if (state_next != S_RUN)
        dac_data <= MID;
      else if (take)
        dac_data <= sel_data;

      if (underflow_clr)
        underflow_cnt <= '0;
      else if (miss && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dac_stream_sched.sv
// Bench for dac_stream_sched: randomized sessions checked cycle by cycle against a timeline
// model derived from start/stop cycle positions, plus directed reset, stop and saturation cases.
module tb_dac_stream_sched;

  localparam int W     = 14;
  localparam int WARM  = 16;
  localparam int DRAIN = 8;
  localparam logic [W-1:0] MID = 14'h2000;

  localparam int P_IDLE = 0;
  localparam int P_WARM = 1;
  localparam int P_RUN  = 2;
  localparam int P_DRN  = 3;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, stop, src_sel, underflow_clr;
  logic [7:0]   rate_div;
  logic [W-1:0] s0_data, s1_data;
  logic         s0_valid, s1_valid;
  logic         s0_ready, s1_ready;
  logic [W-1:0] dac_data;
  logic         dac_en, busy;
  logic [15:0]  underflow_cnt;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_data;
  int           uf;

  dac_stream_sched #(.WIDTH(W), .WARMUP_CYC(WARM), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .src_sel(src_sel),
    .rate_div(rate_div), .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .underflow_clr(underflow_clr), .dac_data(dac_data), .dac_en(dac_en), .busy(busy),
    .underflow_cnt(underflow_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; src_sel = 1'b0; rate_div = 8'd0;
    s0_data = '0; s1_data = '0; s0_valid = 1'b0; s1_valid = 1'b0; underflow_clr = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    uf = 0;
    exp_q.delete();
  endtask

  // Phase during interval k (interval k follows the k-th clock edge after the start edge);
  // ks is the interval in which stop is driven, or -1 for none.
  function automatic int phase_of(int k, int ks);
    if (ks >= 0 && k > ks) return (k <= ks + DRAIN) ? P_DRN : P_IDLE;
    return (k < WARM) ? P_WARM : P_RUN;
  endfunction

  // Driver + reference model for one start..stop session.
  // vmode: 0 always valid, 1 random valid, 2 never valid, 3 invalid on ticks 2 and 3.
  task automatic run_session(input string tag, input logic src, input logic [7:0] rate,
                             input int stop_k, input int n_int, input int vmode,
                             input int clr_k, input bit rnd_clr, input bit do_check);
    logic [W-1:0] ramp0, ramp1, exp_data;
    int ph, r, tnum;
    bit tick, vsel, clr, exp_on, exp_r0, exp_r1;
    r = int'(rate);
    ramp0 = 14'd1;
    ramp1 = 14'h0100;
    last_data = MID;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; stop = 1'b0; src_sel = src; rate_div = rate; underflow_clr = 1'b0;
    for (int k = 0; k < n_int; k++) begin
      @(negedge clk);
      ph = phase_of(k, stop_k);
      start    = (ph != P_IDLE) && ($urandom_range(0, 7) == 0);
      stop     = (k == stop_k) || ((ph == P_DRN || ph == P_IDLE) && ($urandom_range(0, 3) == 0));
      src_sel  = 1'($urandom);
      rate_div = 8'($urandom);
      tick = (ph == P_RUN) && (((k - WARM + 1) % (r + 1)) == 0);
      tnum = (k - WARM + 1) / (r + 1);
      case (vmode)
        0:       vsel = 1'b1;
        1:       vsel = ($urandom_range(0, 3) != 0);
        2:       vsel = 1'b0;
        default: vsel = !(tick && (tnum == 2 || tnum == 3));
      endcase
      s0_valid = src ? 1'($urandom) : vsel;
      s1_valid = src ? vsel : 1'($urandom);
      s0_data  = src ? W'($urandom) : ramp0;
      s1_data  = src ? ramp1 : W'($urandom);
      clr = (k == clr_k) || (rnd_clr && $urandom_range(0, 15) == 0);
      underflow_clr = clr;
      if (ph == P_RUN) begin
        if (exp_q.size() > 0) last_data = exp_q.pop_front();
      end else begin
        exp_q.delete();
      end
      exp_data = (ph == P_RUN) ? last_data : MID;
      exp_on   = (ph != P_IDLE);
      exp_r0   = tick && !src && vsel;
      exp_r1   = tick && src && vsel;
      #1;
      if (do_check) begin
        checks++;
        if (dac_en !== exp_on) begin
          errors++;
          $display("FAIL %s k=%0d dac_en got %0b exp %0b", tag, k, dac_en, exp_on);
        end
        checks++;
        if (busy !== exp_on) begin
          errors++;
          $display("FAIL %s k=%0d busy got %0b exp %0b", tag, k, busy, exp_on);
        end
        checks++;
        if (dac_data !== exp_data) begin
          errors++;
          $display("FAIL %s k=%0d dac_data got %h exp %h", tag, k, dac_data, exp_data);
        end
        checks++;
        if (s0_ready !== exp_r0) begin
          errors++;
          $display("FAIL %s k=%0d s0_ready got %0b exp %0b", tag, k, s0_ready, exp_r0);
        end
        checks++;
        if (s1_ready !== exp_r1) begin
          errors++;
          $display("FAIL %s k=%0d s1_ready got %0b exp %0b", tag, k, s1_ready, exp_r1);
        end
        checks++;
        if (underflow_cnt !== 16'(uf)) begin
          errors++;
          $display("FAIL %s k=%0d underflow_cnt got %0d exp %0d", tag, k, underflow_cnt, uf);
        end
      end
      // effect of the coming clock edge
      if (tick && vsel) begin
        exp_q.push_back(src ? ramp1 : ramp0);
        if (src) ramp1 = ramp1 + 1'b1;
        else     ramp0 = ramp0 + 1'b1;
      end
      if (clr) uf = 0;
      else if (tick && !vsel && uf < 65535) uf++;
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; underflow_clr = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (dac_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle en/busy got %0b/%0b exp 0/0", dac_en, busy);
    end
    checks++;
    if (dac_data !== MID || underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle data/uf got %h/%0d exp %h/0", dac_data, underflow_cnt, MID);
    end
    run_session("reset_run", 1'b0, 8'd1, -1, 30, 2, -1, 1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (dac_en !== 1'b0 || busy !== 1'b0 || s0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_async en/busy/rdy got %0b/%0b/%0b exp 0/0/0", dac_en, busy, s0_ready);
    end
    checks++;
    if (dac_data !== MID || underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_async data/uf got %h/%0d exp %h/0", dac_data, underflow_cnt, MID);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    uf = 0;
  endtask

  task automatic test_stream();
    apply_reset();
    run_session("stream", 1'b0, 8'd3, 40, 52, 0, -1, 1'b0, 1'b1);
    checks++;
    if (underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stream_uf got %0d exp 0", underflow_cnt);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    run_session("underflow", 1'b0, 8'd3, 40, 52, 3, -1, 1'b0, 1'b1);
    checks++;
    if (underflow_cnt !== 16'd2) begin
      errors++;
      $display("FAIL underflow_two got %0d exp 2", underflow_cnt);
    end
  endtask

  task automatic test_tone();
    apply_reset();
    run_session("tone", 1'b1, 8'd0, 40, 52, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_stop();
    apply_reset();
    run_session("stop_run", 1'b0, 8'd2, 25, 40, 1, -1, 1'b0, 1'b1);
    run_session("stop_warm", 1'b1, 8'd1, 5, 20, 1, -1, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b0 || dac_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_end busy/en got %0b/%0b exp 0/0", busy, dac_en);
    end
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || dac_en !== 1'b0 || dac_data !== MID) begin
        errors++;
        $display("FAIL start_stop_idle i=%0d busy/en/data got %0b/%0b/%h exp 0/0/%h",
                 i, busy, dac_en, dac_data, MID);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    run_session("saturate", 1'b0, 8'd0, 65560, 65570, 2, -1, 1'b0, 1'b0);
    checks++;
    if (underflow_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate got %h exp ffff", underflow_cnt);
    end
    run_session("clr_miss", 1'b0, 8'd0, 20, 32, 2, 20, 1'b0, 1'b1);
    checks++;
    if (underflow_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority got %0d exp 0", underflow_cnt);
    end
  endtask

  task automatic test_random();
    int ks;
    apply_reset();
    for (int s = 0; s < 8; s++) begin
      ks = $urandom_range(3, 70);
      run_session("random", 1'($urandom), 8'($urandom_range(0, 5)), ks, ks + DRAIN + 4,
                  1, -1, 1'b1, 1'b1);
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    uf = 0;
    test_reset();
    test_stream();
    test_underflow();
    test_tone();
    test_stop();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
